spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: frame length in bits (legal values 2..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK period; must be even and >= 2; HALF = CLK_DIV/2.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-005 The block SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-006 The block SHALL have port tx_data  input  DATA_W  frame to transmit, MSB first.
REQ-007 The block SHALL have port miso  input  1  serial data from the slave.
REQ-008 The block SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 The block SHALL have port mosi  output  1  serial data to the slave.
REQ-010 The block SHALL have port cs_n  output  1  slave select, active-low.
REQ-011 The block SHALL have port rx_data  output  DATA_W  last received frame, MSB first.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port listo  output  1  one-cycle pulse marking transfer completion.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, SHIFT and DONE, held in one registered state variable.
REQ-015 IDLE->SETUP SHALL occur on the edge E where start=1 in IDLE; tx_data SHALL be captured into the shift register on E; cs_n SHALL go to 0 and mosi SHALL present tx_data[DATA_W-1] from E.
REQ-016 SETUP SHALL last HALF cycles with sclk=0; SETUP->SHIFT SHALL occur at E+HALF with sclk rising to 1.
REQ-017 In SHIFT, sclk SHALL toggle every HALF cycles; rising edges at E+(2k+1)*HALF and falling edges at E+(2k+2)*HALF, for k=0..DATA_W-1.
REQ-018 On each sclk rising edge, miso SHALL be sampled on that same clk edge into the receive shift register LSB, with the register shifting left.
REQ-019 On each sclk falling edge except the last one, mosi SHALL advance to the next lower transmit bit.
REQ-020 A half-period divider counter SHALL count 0..HALF-1 and wrap, and a bit counter SHALL count sampled bits 0..DATA_W-1; neither SHALL overflow its width.
REQ-021 At the last falling edge, E+2*DATA_W*HALF, the state SHALL go to DONE, cs_n SHALL go to 1, sclk SHALL be 0, rx_data SHALL load the receive register, and listo SHALL be 1 for exactly that one cycle.
REQ-022 DONE->IDLE SHALL occur on the next edge; busy SHALL fall with it.
REQ-023 start asserted in SETUP, SHIFT or DONE SHALL be ignored, and tx_data changes after E SHALL have no effect.
REQ-024 If start is held high, the next transfer SHALL be accepted on the first edge in IDLE, giving exactly one IDLE cycle between frames.
REQ-025 rx_data SHALL hold its value between transfers; mosi SHALL be 0 in IDLE.

Reset
REQ-026 While rst=0, the block SHALL asynchronously force: state IDLE, sclk 0, mosi 0, cs_n 1, busy 0, listo 0, rx_data 0, all counters 0.
REQ-027 Reset mid-transfer SHALL abort the transfer without asserting listo; after rst=1, the block SHALL accept start on the first following edge.

Structure
REQ-028 A shared package spi_pkg SHALL hold the state enumeration and the defaults for DATA_W and CLK_DIV.
REQ-029 The divider and bit counting SHALL be one reusable sub-module, spi_bit_counter (enable, wrap limit, terminal-count flag).

Verification
REQ-030 Loopback (miso=mosi), CLK_DIV=4, tx_data=0xA5 -> listo at E+32, rx_data=0xA5, cs_n low during E..E+31.
REQ-031 miso driven with 0x3C MSB-first, one bit per sclk period -> rx_data=0x3C; mosi sequence 1,0,1,0,0,1,0,1 for tx_data=0xA5.
REQ-032 start held high for two frames -> second SETUP at E+34 and second listo at E+66.
REQ-033 start pulsed at E+5 during SHIFT -> ignored: exactly one listo pulse, busy low at E+33.
REQ-034 rst=0 at E+10 -> all outputs at reset values immediately and no listo; start after release -> normal transfer.
REQ-035 CLK_DIV=2, tx_data=0xFF, miso=0 -> listo at E+16, rx_data=0x00, sclk period 2 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI types and defaults: FSM state encoding, parameter defaults and
// a counter-width helper used by the controller and its counter sub-module.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } spi_state_e;

   localparam int SPI_DATA_W_DEF  = 8;
   localparam int SPI_CLK_DIV_DEF = 4;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Wrapping up-counter: counts 0..limit_i while enabled, flags the terminal
// count, and can be cleared synchronously.
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == limit_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_W-bit full-duplex frame per start request,
// MSB first, SCLK derived from clk by CLK_DIV.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W  = SPI_DATA_W_DEF,
   parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              listo
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int DIV_W = cnt_width(HALF);
   localparam int BIT_W = cnt_width(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LIM = DIV_W'(HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LIM = BIT_W'(DATA_W - 1);

   spi_state_e        state_q, state_d;
   logic              sclk_q, sclk_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;

   logic active;
   logic div_tc, tick;
   logic bit_tc, bit_en, bit_clr;

   assign active = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
   assign tick   = active && div_tc;

   spi_bit_counter #(.W(DIV_W)) u_div_cnt (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (!active),
      .en_i    (active),
      .limit_i (DIV_LIM),
      .tc_o    (div_tc)
   );

   spi_bit_counter #(.W(BIT_W)) u_bit_cnt (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (bit_clr),
      .en_i    (bit_en),
      .limit_i (BIT_LIM),
      .tc_o    (bit_tc)
   );

   always_comb begin
      state_d   = state_q;
      sclk_d    = sclk_q;
      tx_d      = tx_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      bit_en    = 1'b0;
      bit_clr   = (state_q == ST_IDLE);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETUP;
               tx_d    = tx_data;
               sclk_d  = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
               sclk_d  = 1'b1;
               rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (sclk_q) begin
                  // Falling edge: either close the frame or move to the next bit.
                  sclk_d = 1'b0;
                  if (bit_tc) begin
                     state_d   = ST_DONE;
                     rx_data_d = rx_sr_q;
                  end else begin
                     tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                     bit_en = 1'b1;
                  end
               end else begin
                  sclk_d  = 1'b1;
                  rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sclk_q    <= 1'b0;
         tx_q      <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         sclk_q    <= sclk_d;
         tx_q      <= tx_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign sclk    = sclk_q;
   assign mosi    = active ? tx_q[DATA_W-1] : 1'b0;
   assign cs_n    = !active;
   assign rx_data = rx_data_q;
   assign busy    = (state_q != ST_IDLE);
   assign listo   = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: CLK_DIV=4 instance (loopback or driven
// miso) plus a CLK_DIV=2 instance, checked against hand-computed timing.
module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] tx_data;
   logic       miso_drv;
   logic       loop_en;
   logic       miso;
   logic       sclk, mosi, cs_n, busy, listo;
   logic [7:0] rx_data;

   logic       start2;
   logic [7:0] tx_data2;
   logic       miso2;
   logic       sclk2, mosi2, cs_n2, busy2, listo2;
   logic [7:0] rx_data2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign miso = loop_en ? mosi : miso_drv;

   spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .miso(miso),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
      .busy(busy), .listo(listo)
   );

   spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data2), .miso(miso2),
      .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .rx_data(rx_data2),
      .busy(busy2), .listo(listo2)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; start2 = 1'b0; tx_data = '0; tx_data2 = '0;
      miso_drv = 1'b0; miso2 = 1'b0; loop_en = 1'b0;
      #2;
      total++; if ({sclk, mosi, cs_n, busy, listo} !== 5'b00100) begin
         bad++; $display("FAIL reset_ctrl got=%b want=00100", {sclk, mosi, cs_n, busy, listo});
      end
      total++; if (rx_data !== 8'h00) begin
         bad++; $display("FAIL reset_rx got=%h want=00", rx_data);
      end
      total++; if ({sclk2, mosi2, cs_n2, busy2, listo2, rx_data2} !== {5'b00100, 8'h00}) begin
         bad++; $display("FAIL reset_dut2 got=%b want=0010000000000", {sclk2, mosi2, cs_n2, busy2, listo2, rx_data2});
      end
      tick(2);
      rst = 1'b1;
      tick(2);
      total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
         bad++; $display("FAIL reset_release busy=%b cs_n=%b want busy=0 cs_n=1", busy, cs_n);
      end
   endtask

   task automatic test_loopback();
      int listo_n, listo_at, csn_bad;
      loop_en = 1'b1; tx_data = 8'hA5; start = 1'b1;
      tick(1);
      start = 1'b0;
      total++; if ({cs_n, busy, mosi, sclk} !== 4'b0110) begin
         bad++; $display("FAIL lb_first got cs_n/busy/mosi/sclk=%b want=0110", {cs_n, busy, mosi, sclk});
      end
      listo_n = 0; listo_at = -1; csn_bad = 0;
      for (int n = 1; n <= 33; n++) begin
         tick(1);
         if (listo) begin listo_n++; listo_at = n; end
         if (n <= 31 && cs_n !== 1'b0) csn_bad++;
         if (n == 32) begin
            total++; if (rx_data !== 8'hA5) begin
               bad++; $display("FAIL lb_rx got=%h want=a5", rx_data);
            end
            total++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b1) begin
               bad++; $display("FAIL lb_done cs_n=%b sclk=%b busy=%b want 1 0 1", cs_n, sclk, busy);
            end
         end
         if (n == 33) begin
            total++; if (busy !== 1'b0 || mosi !== 1'b0) begin
               bad++; $display("FAIL lb_idle busy=%b mosi=%b want 0 0", busy, mosi);
            end
         end
      end
      total++; if (listo_n !== 1 || listo_at !== 32) begin
         bad++; $display("FAIL lb_listo count=%0d at=%0d want count=1 at=32", listo_n, listo_at);
      end
      total++; if (csn_bad !== 0) begin
         bad++; $display("FAIL lb_csn high_cycles=%0d want=0", csn_bad);
      end
   endtask

   task automatic test_miso_pattern();
      logic [7:0] pat, mosi_seq;
      int sclk_bad;
      pat = 8'h3C; mosi_seq = '0; sclk_bad = 0;
      loop_en = 1'b0; tx_data = 8'hA5; start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int n = 0; n <= 32; n++) begin
         if (n < 32 && (n % 4) == 0) begin
            mosi_seq = {mosi_seq[6:0], mosi};
            miso_drv = pat[7 - n / 4];
         end
         if (n < 32 && sclk !== ((n % 4) >= 2)) sclk_bad++;
         if (n == 16) begin
            total++; if (rx_data !== 8'hA5) begin
               bad++; $display("FAIL pat_rx_hold got=%h want=a5", rx_data);
            end
         end
         if (n == 32) begin
            total++; if (rx_data !== 8'h3C || listo !== 1'b1) begin
               bad++; $display("FAIL pat_rx got=%h listo=%b want=3c listo=1", rx_data, listo);
            end
         end
         if (n < 32) tick(1);
      end
      total++; if (mosi_seq !== 8'hA5) begin
         bad++; $display("FAIL pat_mosi_seq got=%b want=10100101", mosi_seq);
      end
      total++; if (sclk_bad !== 0) begin
         bad++; $display("FAIL pat_sclk bad_cycles=%0d want=0", sclk_bad);
      end
      tick(2);
   endtask

   task automatic test_back_to_back();
      int l1, l2, lcnt, setup2;
      l1 = -1; l2 = -1; lcnt = 0; setup2 = -1;
      loop_en = 1'b1; tx_data = 8'h5A; start = 1'b1;
      tick(1);
      for (int n = 1; n <= 68; n++) begin
         tick(1);
         if (listo) begin
            lcnt++;
            if (l1 < 0) l1 = n; else l2 = n;
         end
         if (n > 32 && cs_n === 1'b0 && setup2 < 0) setup2 = n;
         if (n == 34) start = 1'b0;
         if (n == 66) begin
            total++; if (rx_data !== 8'h5A) begin
               bad++; $display("FAIL b2b_rx got=%h want=5a", rx_data);
            end
         end
         if (n == 68) begin
            total++; if (busy !== 1'b0) begin
               bad++; $display("FAIL b2b_idle busy=%b want=0", busy);
            end
         end
      end
      total++; if (setup2 !== 34) begin
         bad++; $display("FAIL b2b_setup2 got=%0d want=34", setup2);
      end
      total++; if (lcnt !== 2 || l1 !== 32 || l2 !== 66) begin
         bad++; $display("FAIL b2b_listo count=%0d first=%0d second=%0d want 2 32 66", lcnt, l1, l2);
      end
   endtask

   task automatic test_start_ignored();
      int lcnt, lat;
      lcnt = 0; lat = -1;
      loop_en = 1'b1; tx_data = 8'hC3; start = 1'b1;
      tick(1);
      start = 1'b0; tx_data = 8'h00;
      for (int n = 1; n <= 40; n++) begin
         tick(1);
         if (listo) begin lcnt++; lat = n; end
         if (n == 4) start = 1'b1;
         if (n == 5) start = 1'b0;
         if (n == 33) begin
            total++; if (busy !== 1'b0) begin
               bad++; $display("FAIL ign_busy got=%b want=0", busy);
            end
         end
      end
      total++; if (lcnt !== 1 || lat !== 32) begin
         bad++; $display("FAIL ign_listo count=%0d at=%0d want 1 32", lcnt, lat);
      end
      total++; if (rx_data !== 8'hC3) begin
         bad++; $display("FAIL ign_txdata rx=%h want=c3", rx_data);
      end
   endtask

   task automatic test_reset_mid();
      int lcnt, lat;
      lcnt = 0; lat = -1;
      loop_en = 1'b1; tx_data = 8'h3C; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);
      rst = 1'b0;
      #1;
      total++; if ({sclk, mosi, cs_n, busy, listo} !== 5'b00100 || rx_data !== 8'h00) begin
         bad++; $display("FAIL mid_reset ctrl=%b rx=%h want ctrl=00100 rx=00", {sclk, mosi, cs_n, busy, listo}, rx_data);
      end
      for (int n = 0; n < 3; n++) begin
         tick(1);
         if (listo) lcnt++;
      end
      rst = 1'b1;
      tx_data = 8'h96; start = 1'b1;
      tick(1);
      start = 1'b0;
      total++; if (cs_n !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL mid_restart cs_n=%b busy=%b want 0 1", cs_n, busy);
      end
      for (int n = 1; n <= 33; n++) begin
         tick(1);
         if (listo) begin lcnt++; lat = n; end
      end
      total++; if (lcnt !== 1 || lat !== 32) begin
         bad++; $display("FAIL mid_listo count=%0d at=%0d want 1 32", lcnt, lat);
      end
      total++; if (rx_data !== 8'h96) begin
         bad++; $display("FAIL mid_rx got=%h want=96", rx_data);
      end
   endtask

   task automatic test_div2();
      int lat, sclk_bad;
      logic [7:0] want;
      for (int run = 0; run < 2; run++) begin
         lat = -1; sclk_bad = 0;
         miso2 = (run == 0);
         want = (run == 0) ? 8'hFF : 8'h00;
         tx_data2 = 8'hFF; start2 = 1'b1;
         tick(1);
         start2 = 1'b0;
         total++; if (mosi2 !== 1'b1 || sclk2 !== 1'b0 || cs_n2 !== 1'b0) begin
            bad++; $display("FAIL div2_first mosi=%b sclk=%b cs_n=%b want 1 0 0", mosi2, sclk2, cs_n2);
         end
         for (int n = 1; n <= 17; n++) begin
            tick(1);
            if (n < 16 && sclk2 !== (n % 2 == 1)) sclk_bad++;
            if (listo2) lat = n;
            if (n == 16) begin
               total++; if (rx_data2 !== want || cs_n2 !== 1'b1 || sclk2 !== 1'b0) begin
                  bad++; $display("FAIL div2_done rx=%h cs_n=%b sclk=%b want rx=%h 1 0", rx_data2, cs_n2, sclk2, want);
               end
            end
         end
         total++; if (lat !== 16) begin
            bad++; $display("FAIL div2_listo at=%0d want=16", lat);
         end
         total++; if (sclk_bad !== 0) begin
            bad++; $display("FAIL div2_sclk bad_cycles=%0d want=0", sclk_bad);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_miso_pattern();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid();
      test_div2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

endmodule
